// File: rtl/bus_matrix_in_stage_if.sv
// Bus bundle for one bus matrix input port: master-side AHB signals,
// decoder/slave-path feedback and the address phase sent to the output stages.
interface bus_matrix_in_stage_if #(
    parameter int ADDR_W = 32
);
    // master side
    logic              HSELS;
    logic [ADDR_W-1:0] HADDRS;
    logic [1:0]        HTRANSS;
    logic              HWRITES;
    logic [2:0]        HSIZES;
    logic [2:0]        HBURSTS;
    logic [3:0]        HPROTS;
    logic              HMASTLOCKS;
    logic              HREADYS;
    logic              HREADYOUTS;
    logic              HRESPS;
    // decoder / slave path
    logic              active_dec;
    logic              readyout_dec;
    logic              resp_dec;
    // towards arbiters and output stages
    logic              req_port;
    logic              sel_op;
    logic [ADDR_W-1:0] addr_op;
    logic [1:0]        trans_op;
    logic              write_op;
    logic [2:0]        size_op;
    logic [2:0]        burst_op;
    logic [3:0]        prot_op;
    logic              mastlock_op;

    modport slave (
        input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS,
        input  HPROTS, HMASTLOCKS, HREADYS,
        input  active_dec, readyout_dec, resp_dec,
        output HREADYOUTS, HRESPS,
        output req_port, sel_op, addr_op, trans_op, write_op,
        output size_op, burst_op, prot_op, mastlock_op
    );

    modport master (
        output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS,
        output HPROTS, HMASTLOCKS, HREADYS,
        output active_dec, readyout_dec, resp_dec,
        input  HREADYOUTS, HRESPS,
        input  req_port, sel_op, addr_op, trans_op, write_op,
        input  size_op, burst_op, prot_op, mastlock_op
    );
endinterface

// File: rtl/bus_matrix_in_stage.sv
// Input stage for one master port of the AHB bus matrix: holds an address
// phase the selected output port could not take, stalls the master until it
// is accepted, and drives the port request and the live/held address phase.
// Ports: HCLK, HRESETn (async, active-low); bus = slave view of the bundle.
module bus_matrix_in_stage #(
    parameter int ADDR_W = 32
) (
    input  logic                        HCLK,
    input  logic                        HRESETn,
    bus_matrix_in_stage_if.slave        bus
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    typedef struct packed {
        logic              sel;
        logic [ADDR_W-1:0] addr;
        logic [1:0]        trans;
        logic              write;
        logic [2:0]        size;
        logic [2:0]        burst;
        logic [3:0]        prot;
        logic              mastlock;
    } aphase_t;

    state_t  state;
    aphase_t held;
    aphase_t live;
    aphase_t cur;
    logic    pend_tran;
    logic    trans_req;

    assign pend_tran = (state == PEND);

    // NONSEQ/SEQ address phase completing at the master this cycle
    assign trans_req = bus.HSELS & bus.HTRANSS[1] & bus.HREADYS;

    assign live = '{
        sel:      bus.HSELS,
        addr:     bus.HADDRS,
        trans:    bus.HTRANSS,
        write:    bus.HWRITES,
        size:     bus.HSIZES,
        burst:    bus.HBURSTS,
        prot:     bus.HPROTS,
        mastlock: bus.HMASTLOCKS
    };

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= IDLE;
            held  <= '0;
        end else begin
            // Capture every completed phase while idle so the register
            // already holds the transfer when PEND is entered.
            if (state == IDLE && bus.HREADYS)
                held <= live;
            unique case (state)
                IDLE: if (trans_req && !bus.active_dec) state <= PEND;
                PEND: if (bus.active_dec)               state <= IDLE;
                default:                                state <= IDLE;
            endcase
        end
    end

    assign cur = pend_tran ? held : live;

    assign bus.sel_op      = cur.sel;
    assign bus.addr_op     = cur.addr;
    assign bus.trans_op    = cur.trans;
    assign bus.write_op    = cur.write;
    assign bus.size_op     = cur.size;
    assign bus.burst_op    = cur.burst;
    assign bus.prot_op     = cur.prot;
    assign bus.mastlock_op = cur.mastlock;

    // BUSY is forwarded on trans_op but never requests the port
    assign bus.req_port   = pend_tran | (bus.HSELS & bus.HTRANSS[1]);

    // Master's data phase is stalled until the held address is accepted
    assign bus.HREADYOUTS = pend_tran ? 1'b0 : bus.readyout_dec;
    assign bus.HRESPS     = pend_tran ? 1'b0 : bus.resp_dec;

endmodule

// File: tb/tb_bus_matrix_in_stage.sv
// Directed testbench for bus_matrix_in_stage.
// Drives after each rising edge, checks combinational outputs before the next.
module tb_bus_matrix_in_stage;

    localparam int ADDR_W = 32;

    logic HCLK;
    logic HRESETn;
    int   checks;
    int   errors;

    bus_matrix_in_stage_if #(.ADDR_W(ADDR_W)) bus ();

    bus_matrix_in_stage #(.ADDR_W(ADDR_W)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus.slave)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic sel, input logic [31:0] addr,
                         input logic [1:0] trans, input logic wr,
                         input logic [2:0] burst, input logic rdy,
                         input logic act);
        bus.HSELS      = sel;
        bus.HADDRS     = addr;
        bus.HTRANSS    = trans;
        bus.HWRITES    = wr;
        bus.HSIZES     = 3'd2;
        bus.HBURSTS    = burst;
        bus.HPROTS     = 4'h3;
        bus.HMASTLOCKS = 1'b0;
        bus.HREADYS    = rdy;
        bus.active_dec = act;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        HRESETn = 1'b0;
        drive(0, 32'h0, 2'd0, 0, 3'd0, 1, 0);
        bus.readyout_dec = 1'b1;
        bus.resp_dec     = 1'b0;
        #12;
        chk("rst_hreadyout", 32'(bus.HREADYOUTS), 32'd1);
        chk("rst_hresp",     32'(bus.HRESPS),     32'd0);
        chk("rst_req",       32'(bus.req_port),   32'd0);
        chk("rst_pend",      32'(dut.pend_tran),  32'd0);
        chk("rst_trans",     32'(bus.trans_op),   32'd0);
        HRESETn = 1'b1;
        step();

        // pass-through, accepted in the same cycle
        drive(1, 32'h2000_0010, 2'd2, 1, 3'd0, 1, 1);
        #1;
        chk("pt_addr",  bus.addr_op,           32'h2000_0010);
        chk("pt_write", 32'(bus.write_op),     32'd1);
        chk("pt_trans", 32'(bus.trans_op),     32'd2);
        chk("pt_req",   32'(bus.req_port),     32'd1);
        step();
        drive(0, 32'h0, 2'd0, 0, 3'd0, 1, 0);
        #1;
        chk("pt_pend",  32'(dut.pend_tran),    32'd0);
        chk("pt_rdy1",  32'(bus.HREADYOUTS),   32'd1);
        bus.readyout_dec = 1'b0;
        #1;
        chk("pt_rdy0",  32'(bus.HREADYOUTS),   32'd0);
        bus.readyout_dec = 1'b1;
        step();

        // held path: INCR4 NONSEQ, accepted 3 cycles after capture
        drive(1, 32'h4000_0000, 2'd2, 0, 3'd3, 1, 0);
        #1;
        chk("hp_req_live", 32'(bus.req_port), 32'd1);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(0, 32'hDEAD_BEEF, 2'd0, 1, 3'd0, 0, (i == 3));
            #1;
            chk($sformatf("hp_addr%0d", i),  bus.addr_op,            32'h4000_0000);
            chk($sformatf("hp_burst%0d", i), 32'(bus.burst_op),      32'd3);
            chk($sformatf("hp_trans%0d", i), 32'(bus.trans_op),      32'd2);
            chk($sformatf("hp_req%0d", i),   32'(bus.req_port),      32'd1);
            chk($sformatf("hp_rdy%0d", i),   32'(bus.HREADYOUTS),    32'd0);
            step();
        end
        drive(0, 32'h0, 2'd0, 0, 3'd0, 1, 0);
        #1;
        chk("hp_pend_clr", 32'(dut.pend_tran),  32'd0);
        chk("hp_rdy_back", 32'(bus.HREADYOUTS), 32'd1);
        chk("hp_trans_idle", 32'(bus.trans_op), 32'd0);
        step();

        // burst: NONSEQ held, accepted while master shows SEQ; BUSY mid-burst
        drive(1, 32'h1000_0000, 2'd2, 1, 3'd3, 1, 0);
        #1;
        chk("bu_b1_live", 32'(bus.trans_op), 32'd2);
        step();
        drive(1, 32'h1000_0004, 2'd3, 1, 3'd3, 0, 1);
        #1;
        chk("bu_b1_held_tr", 32'(bus.trans_op), 32'd2);
        chk("bu_b1_held_ad", bus.addr_op,       32'h1000_0000);
        step();
        drive(1, 32'h1000_0004, 2'd3, 1, 3'd3, 1, 1);
        #1;
        chk("bu_b2_pend", 32'(dut.pend_tran), 32'd0);
        chk("bu_b2_tr",   32'(bus.trans_op),  32'd3);
        chk("bu_b2_ad",   bus.addr_op,        32'h1000_0004);
        step();
        drive(1, 32'h1000_0008, 2'd1, 1, 3'd3, 1, 0);
        #1;
        chk("bu_busy_tr",  32'(bus.trans_op), 32'd1);
        chk("bu_busy_req", 32'(bus.req_port), 32'd0);
        step();
        drive(1, 32'h1000_0008, 2'd3, 1, 3'd3, 1, 1);
        #1;
        chk("bu_b3_pend", 32'(dut.pend_tran), 32'd0);
        chk("bu_b3_tr",   32'(bus.trans_op),  32'd3);
        chk("bu_b3_ad",   bus.addr_op,        32'h1000_0008);
        step();
        drive(1, 32'h1000_000C, 2'd3, 1, 3'd3, 1, 1);
        #1;
        chk("bu_b4_tr",   32'(bus.trans_op),  32'd3);
        chk("bu_b4_ad",   bus.addr_op,        32'h1000_000C);
        step();
        drive(0, 32'h0, 2'd0, 0, 3'd0, 1, 0);
        #1;
        chk("bu_end_pend", 32'(dut.pend_tran), 32'd0);
        step();

        // two-cycle ERROR response from the slave path
        drive(1, 32'h3000_0000, 2'd2, 0, 3'd0, 0, 0);
        bus.resp_dec     = 1'b1;
        bus.readyout_dec = 1'b0;
        #1;
        chk("er_c1_resp", 32'(bus.HRESPS),     32'd1);
        chk("er_c1_rdy",  32'(bus.HREADYOUTS), 32'd0);
        step();
        drive(0, 32'h0, 2'd0, 0, 3'd0, 1, 0);
        bus.readyout_dec = 1'b1;
        #1;
        chk("er_c2_pend", 32'(dut.pend_tran),  32'd0);
        chk("er_c2_resp", 32'(bus.HRESPS),     32'd1);
        chk("er_c2_rdy",  32'(bus.HREADYOUTS), 32'd1);
        step();
        bus.resp_dec = 1'b0;

        // asynchronous reset while a transfer is pending
        drive(1, 32'h5000_0000, 2'd2, 0, 3'd0, 1, 0);
        step();
        drive(0, 32'h0, 2'd0, 0, 3'd0, 0, 0);
        #1;
        chk("rp_pend_set", 32'(dut.pend_tran), 32'd1);
        chk("rp_req_set",  32'(bus.req_port),  32'd1);
        HRESETn = 1'b0;
        #1;
        chk("rp_pend_clr", 32'(dut.pend_tran), 32'd0);
        chk("rp_req_clr",  32'(bus.req_port),  32'd0);
        step();
        HRESETn = 1'b1;
        bus.HREADYS = 1'b1;
        step();
        #1;
        chk("rp_trans_idle", 32'(bus.trans_op),   32'd0);
        chk("rp_req_idle",   32'(bus.req_port),   32'd0);
        chk("rp_rdy",        32'(bus.HREADYOUTS), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
